// File: rtl/procyon_wb_pkg.sv
// Wishbone constants shared by the boot-time bus initiators and the SRAM target.
package procyon_wb_pkg;

  localparam int unsigned WB_CTI_WIDTH = 3;
  localparam int unsigned WB_BTE_WIDTH = 2;

  localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_INCR    = 3'b010;
  localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_EOB     = 3'b111;

  localparam logic [WB_BTE_WIDTH-1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/boot_verify.sv
// Post-boot SRAM read-back checker: replays the boot ROM line by line as
// incrementing Wishbone bursts and reports pass/fail and the first bad address.
module boot_verify
  import procyon_wb_pkg::*;
#(
  parameter int unsigned OPTN_WB_DATA_WIDTH = 32,
  parameter int unsigned OPTN_WB_ADDR_WIDTH = 32,
  parameter int unsigned OPTN_HEX_SIZE      = 0,
  parameter int unsigned OPTN_IC_LINE_SIZE  = 32,
  parameter logic [OPTN_WB_ADDR_WIDTH-1:0] OPTN_BASE_ADDR = '0,
  localparam int unsigned ROM_AW = (OPTN_HEX_SIZE > 1) ? $clog2(OPTN_HEX_SIZE) : 1
) (
  input  logic                              i_wb_clk,
  input  logic                              i_wb_rst,
  input  logic                              i_start,
  input  logic                              i_wb_ack,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]     i_wb_data,
  output logic                              o_wb_cyc,
  output logic                              o_wb_stb,
  output logic                              o_wb_we,
  output logic [WB_CTI_WIDTH-1:0]           o_wb_cti,
  output logic [WB_BTE_WIDTH-1:0]           o_wb_bte,
  output logic [OPTN_WB_DATA_WIDTH/8-1:0]   o_wb_sel,
  output logic [OPTN_WB_ADDR_WIDTH-1:0]     o_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0]     o_wb_data,
  input  logic [OPTN_IC_LINE_SIZE*8-1:0]    i_rom_data,
  output logic [ROM_AW-1:0]                 o_rom_addr,
  output logic                              o_done,
  output logic                              o_pass,
  output logic [OPTN_WB_ADDR_WIDTH-1:0]     o_err_addr
);

  localparam int unsigned DW     = OPTN_WB_DATA_WIDTH;
  localparam int unsigned AW     = OPTN_WB_ADDR_WIDTH;
  localparam int unsigned SELW   = DW / 8;
  localparam int unsigned BEATS  = OPTN_IC_LINE_SIZE / SELW;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ROM_AW-1:0] LAST_LINE = ROM_AW'((OPTN_HEX_SIZE > 0) ? OPTN_HEX_SIZE - 1 : 0);
  localparam logic [WB_CTI_WIDTH-1:0] FIRST_CTI = (BEATS == 1) ? WB_CTI_EOB : WB_CTI_INCR;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

  state_t                  r_state, w_state;
  logic [ROM_AW-1:0]       r_line, w_line;
  logic [BEAT_W-1:0]       r_beat, w_beat, w_beat_inc;
  logic                    r_cyc, w_cyc;
  logic [WB_CTI_WIDTH-1:0] r_cti, w_cti;
  logic [SELW-1:0]         r_sel, w_sel;
  logic [AW-1:0]           r_addr, w_addr;
  logic                    r_done, w_done;
  logic                    r_pass, w_pass;
  logic [AW-1:0]           r_err_addr, w_err_addr;
  logic [DW-1:0]           w_rom_word;

  // Byte address wraps modulo 2^AW by virtue of the AW-bit arithmetic.
  function automatic logic [AW-1:0] f_beat_addr(input logic [ROM_AW-1:0] line,
                                                input logic [BEAT_W-1:0] beat);
    return OPTN_BASE_ADDR + AW'(line) * AW'(OPTN_IC_LINE_SIZE) + AW'(beat) * AW'(SELW);
  endfunction

  assign w_rom_word = i_rom_data[32'(r_beat) * DW +: DW];
  assign w_beat_inc = r_beat + BEAT_W'(1);

  always_comb begin
    w_state    = r_state;
    w_line     = r_line;
    w_beat     = r_beat;
    w_cyc      = r_cyc;
    w_cti      = r_cti;
    w_sel      = r_sel;
    w_addr     = r_addr;
    w_done     = r_done;
    w_pass     = r_pass;
    w_err_addr = r_err_addr;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (OPTN_HEX_SIZE == 0) begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_pass  = 1'b1;
          end else begin
            w_state = S_BURST;
            w_line  = '0;
            w_beat  = '0;
            w_cyc   = 1'b1;
            w_cti   = FIRST_CTI;
            w_sel   = '1;
            w_addr  = f_beat_addr('0, '0);
          end
        end
      end
      S_BURST: begin
        if (r_cyc && i_wb_ack) begin
          if (i_wb_data != w_rom_word) begin
            w_state    = S_DONE;
            w_cyc      = 1'b0;
            w_cti      = WB_CTI_CLASSIC;
            w_sel      = '0;
            w_done     = 1'b1;
            w_pass     = 1'b0;
            w_err_addr = r_addr;
          end else if (r_beat != LAST_BEAT) begin
            w_beat = w_beat_inc;
            w_addr = f_beat_addr(r_line, w_beat_inc);
            w_cti  = (w_beat_inc == LAST_BEAT) ? WB_CTI_EOB : WB_CTI_INCR;
          end else begin
            w_cyc = 1'b0;
            w_cti = WB_CTI_CLASSIC;
            w_sel = '0;
            if (r_line == LAST_LINE) begin
              w_state = S_DONE;
              w_done  = 1'b1;
              w_pass  = 1'b1;
            end else begin
              w_state = S_GAP;
              w_line  = r_line + ROM_AW'(1);
              w_beat  = '0;
            end
          end
        end
      end
      S_GAP: begin
        w_state = S_BURST;
        w_cyc   = 1'b1;
        w_cti   = FIRST_CTI;
        w_sel   = '1;
        w_addr  = f_beat_addr(r_line, '0);
      end
      S_DONE: begin
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_beat     <= '0;
      r_cyc      <= 1'b0;
      r_cti      <= WB_CTI_CLASSIC;
      r_sel      <= '0;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state    <= w_state;
      r_line     <= w_line;
      r_beat     <= w_beat;
      r_cyc      <= w_cyc;
      r_cti      <= w_cti;
      r_sel      <= w_sel;
      r_addr     <= w_addr;
      r_done     <= w_done;
      r_pass     <= w_pass;
      r_err_addr <= w_err_addr;
    end
  end

  assign o_wb_cyc   = r_cyc;
  assign o_wb_stb   = r_cyc;
  assign o_wb_we    = 1'b0;
  assign o_wb_cti   = r_cti;
  assign o_wb_bte   = WB_BTE_LINEAR;
  assign o_wb_sel   = r_sel;
  assign o_wb_addr  = r_addr;
  assign o_wb_data  = '0;
  assign o_rom_addr = r_line;
  assign o_done     = r_done;
  assign o_pass     = r_pass;
  assign o_err_addr = r_err_addr;

endmodule

// File: tb/tb_boot_verify.sv
// Directed bench for boot_verify: two-line pass, corrupted word, wait states,
// mid-burst reset, empty ROM and address wrap at the top of memory.
module tb_boot_verify;
  import procyon_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: two lines, base 0 ----------------
  logic        start_a = 1'b0, ack_a, cyc_a, stb_a, we_a, done_a, pass_a;
  logic [2:0]  cti_a;
  logic [1:0]  bte_a;
  logic [3:0]  sel_a;
  logic [31:0] addr_a, wdat_a, rdat_a, err_a;
  logic [255:0] romd_a;
  logic [0:0]  romaddr_a;
  logic [255:0] rom_a [0:1];
  logic [31:0] mem_a [0:15];

  boot_verify #(.OPTN_WB_DATA_WIDTH(32), .OPTN_WB_ADDR_WIDTH(32), .OPTN_HEX_SIZE(2),
                .OPTN_IC_LINE_SIZE(32), .OPTN_BASE_ADDR(32'h0)) u_dut_a (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start_a), .i_wb_ack(ack_a), .i_wb_data(rdat_a),
    .o_wb_cyc(cyc_a), .o_wb_stb(stb_a), .o_wb_we(we_a), .o_wb_cti(cti_a), .o_wb_bte(bte_a),
    .o_wb_sel(sel_a), .o_wb_addr(addr_a), .o_wb_data(wdat_a), .i_rom_data(romd_a),
    .o_rom_addr(romaddr_a), .o_done(done_a), .o_pass(pass_a), .o_err_addr(err_a));

  logic        ws_mode = 1'b0;
  logic [1:0]  r_wait;
  logic        prev_pending;
  logic [31:0] prev_addr;
  int          stab_err = 0;
  logic [31:0] qa_addr [$];
  logic [2:0]  qa_cti  [$];

  assign romd_a = rom_a[romaddr_a];
  assign rdat_a = mem_a[addr_a[5:2]];
  assign ack_a  = cyc_a & stb_a & (r_wait == 2'd0);

  always @(posedge clk) begin
    if (rst) begin
      r_wait       <= 2'd0;
      prev_pending <= 1'b0;
    end else begin
      if (cyc_a && stb_a) begin
        if (r_wait == 2'd0) r_wait <= ws_mode ? 2'($urandom_range(0, 3)) : 2'd0;
        else                r_wait <= r_wait - 2'd1;
      end
      if (prev_pending && (!stb_a || addr_a !== prev_addr)) stab_err <= stab_err + 1;
      prev_pending <= cyc_a & stb_a & ~ack_a;
      prev_addr    <= addr_a;
      if (cyc_a && stb_a && ack_a) begin
        qa_addr.push_back(addr_a);
        qa_cti.push_back(cti_a);
      end
    end
  end

  // ---------------- DUT B: empty ROM ----------------
  logic        start_b = 1'b0, cyc_b, stb_b, we_b, done_b, pass_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;
  logic [3:0]  sel_b;
  logic [31:0] addr_b, wdat_b, err_b;
  logic [0:0]  romaddr_b;
  logic        b_cyc_seen = 1'b0;

  boot_verify #(.OPTN_WB_DATA_WIDTH(32), .OPTN_WB_ADDR_WIDTH(32), .OPTN_HEX_SIZE(0),
                .OPTN_IC_LINE_SIZE(32), .OPTN_BASE_ADDR(32'h0)) u_dut_b (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start_b), .i_wb_ack(cyc_b), .i_wb_data(32'h0),
    .o_wb_cyc(cyc_b), .o_wb_stb(stb_b), .o_wb_we(we_b), .o_wb_cti(cti_b), .o_wb_bte(bte_b),
    .o_wb_sel(sel_b), .o_wb_addr(addr_b), .o_wb_data(wdat_b), .i_rom_data(256'h0),
    .o_rom_addr(romaddr_b), .o_done(done_b), .o_pass(pass_b), .o_err_addr(err_b));

  always @(posedge clk) if (cyc_b || stb_b) b_cyc_seen <= 1'b1;

  // ---------------- DUT C: one line at the top of the address space ----------------
  logic        start_c = 1'b0, ack_c, cyc_c, stb_c, we_c, done_c, pass_c;
  logic [2:0]  cti_c;
  logic [1:0]  bte_c;
  logic [3:0]  sel_c;
  logic [31:0] addr_c, wdat_c, rdat_c, err_c;
  logic [255:0] rom_c;
  logic [0:0]  romaddr_c;
  logic [31:0] mem_c [0:7];
  logic [2:0]  idx_c;
  logic [31:0] qc_addr [$];
  logic [31:0] exp_c [0:7] = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                               32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};

  boot_verify #(.OPTN_WB_DATA_WIDTH(32), .OPTN_WB_ADDR_WIDTH(32), .OPTN_HEX_SIZE(1),
                .OPTN_IC_LINE_SIZE(32), .OPTN_BASE_ADDR(32'hFFFF_FFF0)) u_dut_c (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start_c), .i_wb_ack(ack_c), .i_wb_data(rdat_c),
    .o_wb_cyc(cyc_c), .o_wb_stb(stb_c), .o_wb_we(we_c), .o_wb_cti(cti_c), .o_wb_bte(bte_c),
    .o_wb_sel(sel_c), .o_wb_addr(addr_c), .o_wb_data(wdat_c), .i_rom_data(rom_c),
    .o_rom_addr(romaddr_c), .o_done(done_c), .o_pass(pass_c), .o_err_addr(err_c));

  assign ack_c  = cyc_c & stb_c;
  assign idx_c  = addr_c[4:2] + 3'd4;
  assign rdat_c = mem_c[idx_c];

  always @(posedge clk) if (!rst && cyc_c && stb_c && ack_c) qc_addr.push_back(addr_c);

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    qa_addr.delete(); qa_cti.delete(); qc_addr.delete();
  endtask

  task automatic wait_done_a(input int max_cycles, input string tag);
    int n = 0;
    while (!done_a && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, done_a, 1'b1);
  endtask

  task automatic check_line_addrs(input string tag);
    for (int i = 0; i < 16; i++)
      if (i < qa_addr.size()) check(tag, qa_addr[i], 32'(i * 4));
  endtask

  initial begin
    int n;
    int gaps;
    logic seen;

    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 8; b++) begin
        rom_a[l][b*32 +: 32] = 32'h1234_0000 + 32'(l * 256) + 32'(b * 17);
        mem_a[l*8 + b]       = 32'h1234_0000 + 32'(l * 256) + 32'(b * 17);
      end
    for (int b = 0; b < 8; b++) begin
      rom_c[b*32 +: 32] = 32'hBEEF_0000 + 32'(b);
      mem_c[b]          = 32'hBEEF_0000 + 32'(b);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc",     cyc_a, 1'b0);
    check("rst_stb",     stb_a, 1'b0);
    check("rst_we",      we_a, 1'b0);
    check("rst_cti",     cti_a, 3'b000);
    check("rst_bte",     bte_a, 2'b00);
    check("rst_sel",     sel_a, 4'h0);
    check("rst_addr",    addr_a, 32'h0);
    check("rst_wdata",   wdat_a, 32'h0);
    check("rst_romaddr", romaddr_a, 1'b0);
    check("rst_done",    done_a, 1'b0);
    check("rst_pass",    pass_a, 1'b0);
    check("rst_err",     err_a, 32'h0);
    check("rst_b_done",  done_b, 1'b0);
    check("rst_c_done",  done_c, 1'b0);
    rst = 1'b0;

    // Two full lines, zero-wait responder
    @(negedge clk);
    start_a = 1'b1;
    n = 0; gaps = 0; seen = 1'b0;
    while (!done_a && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (cyc_a) begin
        seen = 1'b1;
        check("t1_sel", sel_a, 4'hF);
      end else if (seen && !done_a) gaps++;
    end
    check("t1_done_cycle", n, 18);
    check("t1_gaps", gaps, 1);
    check("t1_done", done_a, 1'b1);
    check("t1_pass", pass_a, 1'b1);
    check("t1_err", err_a, 32'h0);
    check("t1_cyc_after", cyc_a, 1'b0);
    check("t1_romaddr", romaddr_a, 1'b1);
    check("t1_beats", qa_addr.size(), 16);
    check_line_addrs("t1_addr");
    for (int i = 0; i < 16; i++)
      if (i < qa_cti.size()) check("t1_cti", qa_cti[i], (i % 8 == 7) ? 3'b111 : 3'b010);
    // Start is ignored once done
    repeat (3) @(posedge clk); #1;
    check("t1_sticky_cyc", cyc_a, 1'b0);
    check("t1_sticky_done", done_a, 1'b1);

    // Corrupted SRAM word at 0x2C
    do_reset();
    mem_a[11] = mem_a[11] ^ 32'h0000_0100;
    start_a = 1'b1;
    wait_done_a(100, "t2_timeout");
    check("t2_pass", pass_a, 1'b0);
    check("t2_err", err_a, 32'h2C);
    check("t2_cyc", cyc_a, 1'b0);
    check("t2_beats", qa_addr.size(), 12);
    if (qa_addr.size() > 0) check("t2_last_addr", qa_addr[qa_addr.size()-1], 32'h2C);
    repeat (2) @(posedge clk); #1;
    check("t2_no_more", qa_addr.size(), 12);
    mem_a[11] = mem_a[11] ^ 32'h0000_0100;

    // Random wait states
    do_reset();
    ws_mode = 1'b1;
    start_a = 1'b1;
    wait_done_a(300, "t3_timeout");
    check("t3_pass", pass_a, 1'b1);
    check("t3_err", err_a, 32'h0);
    check("t3_beats", qa_addr.size(), 16);
    check("t3_stable", stab_err, 0);
    check_line_addrs("t3_addr");
    ws_mode = 1'b0;

    // Reset mid-burst while beat 3 is presented
    do_reset();
    start_a = 1'b1;
    n = 0;
    while (addr_a !== 32'hC && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_beat3", addr_a, 32'hC);
    check("t5_beats_before", qa_addr.size(), 3);
    rst = 1'b1; start_a = 1'b0;
    @(posedge clk); #1;
    check("t5_cyc", cyc_a, 1'b0);
    check("t5_stb", stb_a, 1'b0);
    check("t5_cti", cti_a, 3'b000);
    check("t5_sel", sel_a, 4'h0);
    check("t5_addr", addr_a, 32'h0);
    check("t5_romaddr", romaddr_a, 1'b0);
    check("t5_done", done_a, 1'b0);
    check("t5_pass", pass_a, 1'b0);
    check("t5_err", err_a, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    qa_addr.delete(); qa_cti.delete(); qc_addr.delete();
    start_a = 1'b1;
    @(posedge clk); #1;
    check("t5_restart_cyc", cyc_a, 1'b1);
    check("t5_restart_addr", addr_a, 32'h0);
    check("t5_restart_cti", cti_a, 3'b010);
    wait_done_a(100, "t5_timeout");
    check("t5_final_pass", pass_a, 1'b1);
    check("t5_final_beats", qa_addr.size(), 16);

    // Empty ROM: immediate pass without bus activity
    do_reset();
    start_b = 1'b1;
    @(posedge clk); #1;
    check("t4_done", done_b, 1'b1);
    check("t4_pass", pass_b, 1'b1);
    check("t4_err", err_b, 32'h0);
    check("t4_cyc", cyc_b, 1'b0);
    check("t4_sel", sel_b, 4'h0);
    check("t4_cti", cti_b, 3'b000);
    repeat (3) @(posedge clk); #1;
    check("t4_no_cyc", b_cyc_seen, 1'b0);
    check("t4_misc", {we_b, bte_b, addr_b, wdat_b, romaddr_b}, '0);

    // Address wrap at the top of the address space
    start_c = 1'b1;
    n = 0;
    while (!done_c && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (cyc_c) check("t6_sel", sel_c, 4'hF);
    end
    check("t6_done", done_c, 1'b1);
    check("t6_pass", pass_c, 1'b1);
    check("t6_err", err_c, 32'h0);
    check("t6_beats", qc_addr.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < qc_addr.size()) check("t6_addr", qc_addr[i], exp_c[i]);
    check("t6_misc", {we_c, bte_c, wdat_c, cti_c, romaddr_c}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
